vend_ctrl_param: RTL

Parametrised vending controller: the next generation of the fixed three-can, fixed-price machine. It accepts 10/50/100 coins and holds the accumulated credit, and it serves any of `NUM_CANS` products at per-product prices. Change is returned as a serial train of coin pulses. It sits between the coin acceptor / selection buttons and the dispenser and change hopper drivers.

---
 rtl/vend_ctrl_param.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: coin credit, per-product prices, serial change payout.
// Optional per-product stock counters are built when VEND_STOCK_EN is defined.
module vend_ctrl_param #(
  parameter int                           NUM_CANS   = 3,
  parameter int                           CREDIT_W   = 8,
  parameter logic [NUM_CANS*CREDIT_W-1:0] PRICE_VEC  = {8'd15, 8'd10, 8'd5},
  parameter int                           MAX_CREDIT = 25,
  parameter int                           STOCK_W    = 4,
  parameter int                           STOCK_INIT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin10,
  input  logic                coin50,
  input  logic                coin100,
  input  logic [NUM_CANS-1:0] sel,
  input  logic                cancel,
  input  logic [NUM_CANS-1:0] refill,
  output logic [NUM_CANS-1:0] can,
  output logic                chg10,
  output logic                chg50,
  output logic                chg100,
  output logic                coin_reject,
  output logic                sel_deny,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic [NUM_CANS-1:0] sold_out
);

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

  state_t state, state_next;
  logic [CREDIT_W-1:0] credit_next;
  logic [NUM_CANS-1:0] can_next;
  logic chg10_next, chg50_next, chg100_next, coin_reject_next, sel_deny_next, busy_next;

  logic [1:0]          coin_cnt;
  logic                coin_any, coin_one, coin_fits;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                sel_any;
  logic [NUM_CANS-1:0] sel_low;
  logic [NUM_CANS-1:0] stock_ok;
  logic [CREDIT_W-1:0] price_sel;
  logic                sel_stocked;
  logic                pay10, pay5;
  logic [CREDIT_W-1:0] pay_val;
  logic                vend_go, deny, reject, step;

  // Coin decode; the ceiling check is one bit wider so it can never wrap.
  assign coin_cnt  = {1'b0, coin10} + {1'b0, coin50} + {1'b0, coin100};
  assign coin_any  = coin10 | coin50 | coin100;
  assign coin_one  = (coin_cnt == 2'd1);
  assign coin_val  = coin100 ? CREDIT_W'(10) : coin50 ? CREDIT_W'(5) : CREDIT_W'(1);
  assign coin_sum  = {1'b0, credit} + {1'b0, coin_val};
  assign coin_fits = (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

  // Isolate the lowest set select bit so it wins over the others.
  assign sel_any = |sel;
  assign sel_low = sel & (~sel + NUM_CANS'(1));

  always_comb begin
    price_sel   = '0;
    sel_stocked = 1'b0;
    for (int i = 0; i < NUM_CANS; i++) begin
      if (sel_low[i]) begin
        price_sel   = PRICE_VEC[i*CREDIT_W +: CREDIT_W];
        sel_stocked = stock_ok[i];
      end
    end
  end

  // Greedy change coin for the current remaining credit.
  assign pay10   = (credit >= CREDIT_W'(10));
  assign pay5    = !pay10 && (credit >= CREDIT_W'(5));
  assign pay_val = pay10 ? CREDIT_W'(10) : pay5 ? CREDIT_W'(5) : CREDIT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      credit      <= '0;
      can         <= '0;
      chg10       <= 1'b0;
      chg50       <= 1'b0;
      chg100      <= 1'b0;
      coin_reject <= 1'b0;
      sel_deny    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      credit      <= credit_next;
      can         <= can_next;
      chg10       <= chg10_next;
      chg50       <= chg50_next;
      chg100      <= chg100_next;
      coin_reject <= coin_reject_next;
      sel_deny    <= sel_deny_next;
      busy        <= busy_next;
    end
  end

  // Priority in IDLE/CREDIT: cancel, then select, then coins.
  always_comb begin
    state_next  = state;
    credit_next = credit;
    vend_go     = 1'b0;
    deny        = 1'b0;
    reject      = 1'b0;
    step        = 1'b0;
    case (state)
      S_IDLE, S_CREDIT: begin
        if (cancel && state == S_CREDIT) begin
          reject      = coin_any;
          step        = 1'b1;
          credit_next = credit - pay_val;
          state_next  = S_CHANGE;
        end else if (sel_any) begin
          reject = coin_any;
          if (state == S_CREDIT && credit >= price_sel && sel_stocked) begin
            vend_go     = 1'b1;
            credit_next = credit - price_sel;
            state_next  = S_VEND;
          end else begin
            deny = 1'b1;
          end
        end else if (coin_any) begin
          if (coin_one && coin_fits) begin
            credit_next = coin_sum[CREDIT_W-1:0];
            state_next  = S_CREDIT;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_VEND, S_CHANGE: begin
        reject = coin_any;
        if (credit != '0) begin
          step        = 1'b1;
          credit_next = credit - pay_val;
          state_next  = S_CHANGE;
        end else begin
          state_next  = S_IDLE;
        end
      end
      default: begin
        state_next  = S_IDLE;
        credit_next = '0;
      end
    endcase
  end

  always_comb begin
    can_next         = vend_go ? sel_low : '0;
    chg100_next      = step && pay10;
    chg50_next       = step && pay5;
    chg10_next       = step && !pay10 && !pay5;
    coin_reject_next = reject;
    sel_deny_next    = deny;
    busy_next        = (state_next == S_VEND) || (state_next == S_CHANGE);
  end

`ifdef VEND_STOCK_EN
  logic [STOCK_W-1:0] stock      [NUM_CANS];
  logic [STOCK_W-1:0] stock_next [NUM_CANS];

  // A refill overrides a same-cycle vend of that product.
  generate
    for (genvar gi = 0; gi < NUM_CANS; gi++) begin : g_stock
      assign stock_ok[gi]   = (stock[gi] != '0);
      assign stock_next[gi] = refill[gi] ? STOCK_W'(STOCK_INIT) :
                              (vend_go && sel_low[gi]) ? stock[gi] - STOCK_W'(1) : stock[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CANS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
      sold_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CANS; i++) begin
        stock[i]    <= stock_next[i];
        sold_out[i] <= (stock_next[i] == '0);
      end
    end
  end
`else
  logic               unused_refill;
  logic [STOCK_W-1:0] unused_stock_init;
  assign unused_refill     = ^refill;
  assign unused_stock_init = STOCK_W'(STOCK_INIT);
  assign stock_ok          = '1;
  assign sold_out          = '0;
`endif

endmodule
